// File: rtl/store_narrow.sv
// Store-side narrowing for the MEM stage: lane-replicates a register value, builds
// little-endian byte enables and runs one req/ack write with misalign/timeout checks.
module store_narrow #(
  parameter int NBITS    = 32,
  parameter int ADDRBITS = 32,
  parameter int MAXWAIT  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [ADDRBITS-1:0] i_addr,
  input  logic [NBITS-1:0]    i_data,
  input  logic [1:0]          i_size,
  output logic                o_ready,
  output logic                o_stall,
  output logic                o_mem_req,
  output logic [ADDRBITS-1:0] o_mem_addr,
  output logic [NBITS-1:0]    o_mem_wdata,
  output logic [3:0]          o_mem_be,
  input  logic                i_mem_ack,
  output logic                o_done,
  output logic                o_misalign,
  output logic                o_timeout
);

  localparam int CW = $clog2(MAXWAIT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_req;
  logic [ADDRBITS-1:0] r_addr;
  logic [NBITS-1:0]    r_wdata;
  logic [3:0]          r_be;
  logic                r_done;
  logic                r_misalign;
  logic                r_timeout;

  logic                w_bad;
  logic [NBITS-1:0]    w_wdata;
  logic [3:0]          w_be;

  // Decode of the incoming request; only ever feeds the registers below.
  always_comb begin
    w_bad   = 1'b0;
    w_wdata = i_data;
    w_be    = 4'b0000;
    case (i_size)
      2'b00: begin
        w_wdata = {4{i_data[7:0]}};
        w_be    = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{i_data[15:0]}};
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_bad   = i_addr[0];
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_bad   = |i_addr[1:0];
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 4'b0000;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            if (w_bad) begin
              r_state    <= ERR;
              r_misalign <= 1'b1;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_addr  <= {i_addr[ADDRBITS-1:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + CW'(1);
          // Ack wins over an expiring count on the same edge.
          if (i_mem_ack) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_cnt == CW'(MAXWAIT - 1)) begin
            r_state   <= ERR;
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_misalign <= 1'b0;
          r_timeout  <= 1'b0;
          r_be       <= 4'b0000;
        end
      endcase
    end
  end

  assign o_ready     = (r_state == IDLE);
  assign o_stall     = (r_state != IDLE);
  assign o_mem_req   = r_req;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_be    = r_be;
  assign o_done      = r_done;
  assign o_misalign  = r_misalign;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: expectations are queued when a store is driven
// and popped when the DUT presents the write (or the rejection/abort).
module tb_store_narrow;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] data;
  logic [1:0]  size;
  logic        ready;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        misalign;
  logic        timeout;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          kind;   // 0 done, 1 misalign, 2 timeout
  } exp_t;

  exp_t sb_q[$];

  store_narrow #(.NBITS(32), .ADDRBITS(32), .MAXWAIT(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_addr     (addr),
    .i_data     (data),
    .i_size     (size),
    .o_ready    (ready),
    .o_stall    (stall),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_be   (mem_be),
    .i_mem_ack  (mem_ack),
    .o_done     (done),
    .o_misalign (misalign),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ackdly: edges after acceptance at which ack is sampled (0 = never ack).
  // noise: scramble i_valid/i_data while the request is pending.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input int ackdly, input bit noise, input exp_t e);
    exp_t got;
    int   cnt;
    @(negedge clk);
    chk("ready_before", {31'd0, ready}, 32'd1);
    valid = 1'b1; addr = a; data = d; size = s;
    sb_q.push_back(e);
    @(negedge clk);
    valid = 1'b0;
    addr  = 32'hDEAD_BEE0; data = 32'h5A5A_5A5A; size = 2'b10;
    got = sb_q.pop_front();
    chk("stall_busy", {31'd0, stall}, 32'd1);
    if (got.kind == 1) begin
      chk("misalign_pulse", {31'd0, misalign}, 32'd1);
      chk("req_stays_low", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      chk("misalign_clear", {31'd0, misalign}, 32'd0);
      chk("ready_after_err", {31'd0, ready}, 32'd1);
      $display("[TB] store addr=%h size=%0d rejected", a, s);
      return;
    end
    chk("req_high", {31'd0, mem_req}, 32'd1);
    chk("mem_addr", mem_addr, got.addr);
    chk("mem_wdata", mem_wdata, got.wdata);
    chk("mem_be", {28'd0, mem_be}, {28'd0, got.be});
    if (got.kind == 2) begin
      cnt = 0;
      for (int i = 0; i < 40 && mem_req; i++) begin
        cnt++;
        if (done) chk("no_done_timeout", {31'd0, done}, 32'd0);
        @(negedge clk);
      end
      chk("req_cycles", cnt, 16);
      chk("timeout_pulse", {31'd0, timeout}, 32'd1);
      chk("no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("timeout_clear", {31'd0, timeout}, 32'd0);
      chk("ready_after_to", {31'd0, ready}, 32'd1);
      chk("be_cleared_to", {28'd0, mem_be}, 32'd0);
      $display("[TB] store addr=%h timed out after %0d cycles", a, cnt);
      return;
    end
    for (int i = 1; i < ackdly; i++) begin
      if (noise) begin
        valid = 1'($urandom);
        data  = $urandom;
        addr  = $urandom;
      end
      @(negedge clk);
      chk("req_hold", {31'd0, mem_req}, 32'd1);
      chk("stall_hold", {31'd0, stall}, 32'd1);
      chk("wdata_hold", mem_wdata, got.wdata);
      chk("be_hold", {28'd0, mem_be}, {28'd0, got.be});
    end
    valid = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("no_timeout", {31'd0, timeout}, 32'd0);
    chk("req_dropped", {31'd0, mem_req}, 32'd0);
    chk("ready_in_done", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("done_clear", {31'd0, done}, 32'd0);
    chk("ready_after_done", {31'd0, ready}, 32'd1);
    chk("be_cleared", {28'd0, mem_be}, 32'd0);
    $display("[TB] store addr=%h wdata=%h be=%b done", a, got.wdata, got.be);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; valid = 1'b0; addr = '0; data = '0; size = '0; mem_ack = 1'b0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_pulses", {29'd0, done, misalign, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    e = '{addr: 32'h1000, wdata: 32'h7878_7878, be: 4'b1000, kind: 0};
    store(32'h1003, 32'h1234_5678, 2'b00, 1, 1'b0, e);
    e = '{addr: 32'h2000, wdata: 32'hBEEF_BEEF, be: 4'b1100, kind: 0};
    store(32'h2002, 32'h0000_BEEF, 2'b01, 2, 1'b0, e);
    e = '{addr: 32'h2000, wdata: 32'hBEEF_BEEF, be: 4'b0011, kind: 0};
    store(32'h2000, 32'h0000_BEEF, 2'b01, 1, 1'b0, e);
    e = '{addr: 32'h2004, wdata: 32'hF00F_000F, be: 4'b1111, kind: 0};
    store(32'h2004, 32'hF00F_000F, 2'b10, 1, 1'b0, e);
    e = '{addr: 32'h4000, wdata: 32'hABAB_ABAB, be: 4'b0010, kind: 0};
    store(32'h4001, 32'h0000_00AB, 2'b00, 1, 1'b0, e);

    e = '{addr: 32'h0, wdata: 32'h0, be: 4'b0000, kind: 1};
    store(32'h3001, 32'h1111_1111, 2'b01, 1, 1'b0, e);
    store(32'h3002, 32'h2222_2222, 2'b10, 1, 1'b0, e);
    store(32'h3000, 32'h3333_3333, 2'b11, 1, 1'b0, e);
    e = '{addr: 32'h3000, wdata: 32'h4444_4444, be: 4'b1111, kind: 0};
    store(32'h3000, 32'h4444_4444, 2'b10, 1, 1'b0, e);

    e = '{addr: 32'h5000, wdata: 32'hCAFE_F00D, be: 4'b1111, kind: 2};
    store(32'h5000, 32'hCAFE_F00D, 2'b10, 0, 1'b0, e);
    e = '{addr: 32'h5004, wdata: 32'h0102_0304, be: 4'b1111, kind: 0};
    store(32'h5004, 32'h0102_0304, 2'b10, 16, 1'b0, e);
    e = '{addr: 32'h6004, wdata: 32'h9999_9999, be: 4'b0100, kind: 0};
    store(32'h6006, 32'h0000_0099, 2'b00, 5, 1'b1, e);

    // Asynchronous reset between edges while a write is pending.
    @(negedge clk);
    valid = 1'b1; addr = 32'h7000; data = 32'h7777_7777; size = 2'b10;
    @(negedge clk);
    valid = 1'b0;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_be", {28'd0, mem_be}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_done", {31'd0, done}, 32'd0);
    $display("[TB] reset applied mid-request");
    @(negedge clk);
    rst_n = 1'b1;
    e = '{addr: 32'h8000, wdata: 32'h5555_5555, be: 4'b0001, kind: 0};
    store(32'h8000, 32'h0000_0055, 2'b00, 1, 1'b0, e);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of run");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-side counterpart to the immediate/load sign-extension path in the MEM stage.
- Narrows a 32-bit register value to a byte, halfword or word store.
- Replicates the value onto the correct byte lanes and generates little-endian byte-enables.
- Drives a single-outstanding req/ack write transaction to data memory, with misalignment and timeout detection; the pipeline is stalled while a store is in flight.

Parameters:
- NBITS, 32, data word width; fixed at 32 (byte-enable width is NBITS/8 = 4).
- ADDRBITS, 32, byte address width.
- MAXWAIT, 16, maximum cycles o_mem_req may remain unacknowledged before abort; must be >= 2.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  store request from MEM stage.
- i_addr  in  ADDRBITS  byte address of store.
- i_data  in  NBITS  register value to store (rt).
- i_size  in  2  00 byte (SB), 01 half (SH), 10 word (SW), 11 reserved.
- o_ready  out  1  high only in IDLE; request accepted when i_valid & o_ready at a clock edge.
- o_stall  out  1  high whenever state != IDLE.
- o_mem_req  out  1  write request to data memory.
- o_mem_addr  out  ADDRBITS  word-aligned address: {i_addr[ADDRBITS-1:2], 2'b00}.
- o_mem_wdata  out  NBITS  lane-replicated write data.
- o_mem_be  out  4  byte enables, bit n = byte lane n (bits 8n+7:8n).
- i_mem_ack  in  1  memory write acknowledge.
- o_done  out  1  one-cycle pulse: store completed.
- o_misalign  out  1  one-cycle pulse: request rejected (misaligned or reserved size).
- o_timeout  out  1  one-cycle pulse: store aborted, no ack within MAXWAIT.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - o_mem_req, o_mem_addr, o_mem_wdata, o_mem_be, o_done, o_misalign, o_timeout, o_stall all go to 0; o_ready goes to 1.
  - Wait counter goes to 0.
  - An in-flight request is dropped with no o_done.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- States: IDLE, REQ, DONE, ERR.
- IDLE, with i_valid sampled high at an edge:
  - Reject if any of: size 11; half with addr[0]=1; word with addr[1:0]!=00.
  - On reject: go to ERR with o_misalign=1; o_mem_req stays 0 and memory outputs are unchanged.
  - Otherwise latch address, data and byte-enables, set o_mem_req=1, clear the counter, and go to REQ.
- Lane and byte-enable rules (little-endian):
  - Byte: wdata = {4{i_data[7:0]}}; be = 4'b0001 << addr[1:0].
  - Half: wdata = {2{i_data[15:0]}}; be = addr[1] ? 1100 : 0011.
  - Word: wdata = i_data; be = 1111.
- REQ:
  - o_mem_req, o_mem_addr, o_mem_wdata and o_mem_be are held stable.
  - Counter increments each cycle.
  - i_mem_ack sampled high: go to DONE, o_mem_req=0, o_done=1.
  - Else if counter == MAXWAIT-1: go to ERR, o_mem_req=0, o_timeout=1.
  - Ack takes priority over timeout on the same edge.
- DONE and ERR:
  - Each lasts exactly one cycle, then goes to IDLE.
  - The pulse output clears on exit.
  - o_mem_be returns to 0 on exit; o_mem_addr and o_mem_wdata may hold their last value.
- Latency:
  - Accept at edge k; o_mem_req high from k+1.
  - Ack sampled at edge k+n gives o_done high during cycle k+n+1.
  - o_ready is high again from k+n+2.
  - Minimum store occupancy is 3 cycles (ack at first REQ edge).
- i_mem_ack outside REQ is ignored.
- i_valid outside IDLE is ignored; the MEM stage must hold it under o_stall.
- i_addr, i_data and i_size may change freely after acceptance.
- Back-to-back stores: the next request is accepted on the first edge in IDLE.

Test Plan:
- SB, addr=0x1003, data=0x12345678, ack 1 cycle after req -> o_mem_addr=0x1000, wdata=0x78787878, be=1000, o_done pulses once, o_ready high 2 cycles after ack edge.
- SH, addr=0x2002, data=0x0000BEEF -> wdata=0xBEEFBEEF, be=1100; SH addr=0x2000 -> be=0011; SW addr=0x2004, data=0xF00F000F -> wdata=0xF00F000F, be=1111.
- SH addr=0x3001, SW addr=0x3002, size=11 addr=0x3000 -> each gives one o_misalign pulse, o_mem_req never asserts, next request accepted normally.
- SW with i_mem_ack held 0 -> o_mem_req high exactly MAXWAIT=16 cycles, then o_timeout pulse; o_done never asserts; ack arriving on the same edge the count expires -> o_done, not o_timeout.
- Ack delayed 5 cycles while wdata and be must not change; i_valid toggled and i_data changed during REQ -> no effect, o_stall high throughout.
- Assert i_rst_n=0 mid-REQ, asynchronously between edges -> o_mem_req, o_stall and o_mem_be drop immediately and o_ready rises; after release a new SB completes normally.
